pipe_stage_reg: RTL

- Parametrised inter-stage pipeline register. It is the generic successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of DW bits with a valid bit, a ready/valid handshake and an optional 2-entry skid buffer, so multi-cycle units (mult/div) can back-pressure upstream without combinational ready paths.
- Flush inserts a bubble. Optionally the bubble preserves a PC field for precise-exception/EPC tracking.

---
 rtl/pipe_stage_reg.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready
// handshake, optional 2-entry skid buffer and flush-to-bubble.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_data      upstream payload, in_ready back to upstream
//   out_valid/out_data    downstream payload, out_ready from downstream
//   flush, flush_pc       kill all entries, optional PC kept in bubble
//   occupancy             live entries held (0..2)
module pipe_stage_reg #(
  parameter int DW      = 128,
  parameter int SKID    = 1,
  parameter int KEEP_PC = 0,
  parameter int PC_LSB  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  output logic [1:0]    occupancy
);

  logic          m_valid;
  logic          s_valid;
  logic [DW-1:0] m_data;
  logic [DW-1:0] bubble;
  logic          accept;
  logic          consume;

  assign accept  = in_valid & in_ready;
  assign consume = m_valid & out_ready;

  always_comb begin
    bubble = '0;
    if (KEEP_PC != 0) begin
      bubble[PC_LSB +: 32] = flush_pc;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DW-1:0] s_data;

      // ready depends only on state: no comb path from out_ready
      assign in_ready = ~s_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
          m_data  <= '0;
          s_data  <= '0;
        end else if (flush) begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
          m_data  <= bubble;
        end else if (s_valid) begin
          // in_ready is low, so only a drain of S into M can happen
          if (consume) begin
            m_data  <= s_data;
            s_valid <= 1'b0;
          end
        end else if (!m_valid || consume) begin
          m_valid <= accept;
          if (accept) begin
            m_data <= in_data;
          end
        end else if (accept) begin
          s_data  <= in_data;
          s_valid <= 1'b1;
        end
      end
    end else begin : g_reg
      assign in_ready = out_ready | ~m_valid;
      assign s_valid  = 1'b0;

      always_ff @(posedge clk) begin
        if (reset) begin
          m_valid <= 1'b0;
          m_data  <= '0;
        end else if (flush) begin
          m_valid <= 1'b0;
          m_data  <= bubble;
        end else if (accept) begin
          m_valid <= 1'b1;
          m_data  <= in_data;
        end else if (consume) begin
          m_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule
